// File: rtl/hazard_unit.sv
// hazard_unit: operand forwarding, load-use stall, branch flush and mul/div
// sequencing for the 5-stage RV32 pipeline. A BUSY state freezes F/D/E and
// bubbles M while the mul/div unit runs, guarded by a watchdog.
// Optional HAZARD_PERF_EN adds stall-cycle and flush performance counters.
module hazard_unit #(
    parameter int unsigned REG_ADDR_WIDTH  = 5,
    parameter int unsigned MAX_BUSY_CYCLES = 40,
    parameter int unsigned CNT_WIDTH       = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
    input  logic                      ResultSrcE0_i,
    input  logic                      PCSrcE_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdW_i,
    input  logic                      RegWriteM_i,
    input  logic                      RegWriteW_i,
    input  logic                      MulDivStartE_i,
    input  logic                      MulDivDone_i,
    output logic [1:0]                ForwardAE_o,
    output logic [1:0]                ForwardBE_o,
    output logic                      StallF_o,
    output logic                      StallD_o,
    output logic                      StallE_o,
    output logic                      FlushD_o,
    output logic                      FlushE_o,
    output logic                      FlushM_o,
    output logic                      MulDivGo_o,
    output logic                      MulDivAbort_o,
`ifdef HAZARD_PERF_EN
    output logic [31:0]               StallCycles_o,
    output logic [31:0]               FlushCount_o,
`endif
    output logic                      Timeout_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_BUSY_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

    logic [0:0]           state;
    logic [0:0]           state_nxt;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_nxt;
    logic                 timeout_nxt;
    logic                 lw_stall;
    logic                 expired;

    assign lw_stall = ResultSrcE0_i && (RdE_i != '0) &&
                      ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
    assign expired  = (count >= CNT_MAX);

    // Execute-stage operand forwarding; M beats W, x0 never forwarded
    always_comb begin
        ForwardAE_o = 2'b00;
        ForwardBE_o = 2'b00;
        if (RegWriteM_i && (RdM_i != '0) && (RdM_i == Rs1E_i))
            ForwardAE_o = 2'b10;
        else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == Rs1E_i))
            ForwardAE_o = 2'b01;
        if (RegWriteM_i && (RdM_i != '0) && (RdM_i == Rs2E_i))
            ForwardBE_o = 2'b10;
        else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == Rs2E_i))
            ForwardBE_o = 2'b01;
        if (!rst_n) begin
            ForwardAE_o = 2'b00;
            ForwardBE_o = 2'b00;
        end
    end

    // State, watchdog count and sticky timeout registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= CNT_ZERO;
            Timeout_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            Timeout_o <= timeout_nxt;
        end
    end

    // Next-state and stall/flush/handshake decode
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        timeout_nxt   = Timeout_o;
        StallF_o      = 1'b0;
        StallD_o      = 1'b0;
        StallE_o      = 1'b0;
        FlushD_o      = 1'b0;
        FlushE_o      = 1'b0;
        FlushM_o      = 1'b0;
        MulDivGo_o    = 1'b0;
        MulDivAbort_o = 1'b0;
        case (state)
            IDLE: begin
                StallF_o = lw_stall;
                StallD_o = lw_stall;
                FlushD_o = PCSrcE_i;
                FlushE_o = lw_stall | PCSrcE_i;
                if (MulDivStartE_i) begin
                    MulDivGo_o = 1'b1;
                    // single-cycle ops complete without entering BUSY
                    if (!MulDivDone_i) begin
                        StallF_o  = 1'b1;
                        StallD_o  = 1'b1;
                        StallE_o  = 1'b1;
                        FlushM_o  = 1'b1;
                        state_nxt = BUSY;
                        count_nxt = CNT_ONE;
                    end
                end
            end
            BUSY: begin
                if (MulDivDone_i) begin
                    state_nxt = IDLE;
                    count_nxt = CNT_ZERO;
                end else if (expired) begin
                    MulDivAbort_o = 1'b1;
                    timeout_nxt   = 1'b1;
                    state_nxt     = IDLE;
                    count_nxt     = CNT_ZERO;
                end else begin
                    StallF_o  = 1'b1;
                    StallD_o  = 1'b1;
                    StallE_o  = 1'b1;
                    FlushM_o  = 1'b1;
                    count_nxt = (count < CNT_MAX) ? count + CNT_ONE : count;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = CNT_ZERO;
            end
        endcase
        if (!rst_n) begin
            StallF_o      = 1'b0;
            StallD_o      = 1'b0;
            StallE_o      = 1'b0;
            FlushD_o      = 1'b0;
            FlushE_o      = 1'b0;
            FlushM_o      = 1'b0;
            MulDivGo_o    = 1'b0;
            MulDivAbort_o = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    // Performance counters: stalled cycles and execute flushes, wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCycles_o <= '0;
            FlushCount_o  <= '0;
        end else begin
            if (StallF_o || StallD_o || StallE_o)
                StallCycles_o <= StallCycles_o + 32'd1;
            if (FlushE_o)
                FlushCount_o <= FlushCount_o + 32'd1;
        end
    end
`endif

endmodule
